// File: rtl/sprite_motion_ctrl.sv
// Pac-Man sprite motion controller: merges keypad/PS-2 turns, probes a collision checker per tick.
// Define WRAP_TUNNEL_EN to make horizontal moves past either edge wrap around instead of blocking.
module sprite_motion_ctrl #(
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned X_INIT   = 320,
    parameter int unsigned Y_INIT   = 146,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned Y_MAX    = 479,
    parameter int unsigned STEP     = 1,
    parameter int unsigned TICK_DIV = 262144,
    parameter int unsigned PROBE_TO = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_pad_valid,
    input  logic [4:0]     i_pad_code,
    input  logic           i_kbd_valid,
    input  logic [7:0]     i_kbd_code,
    output logic           o_probe_req,
    output logic [X_W-1:0] o_probe_x,
    output logic [Y_W-1:0] o_probe_y,
    input  logic           i_probe_ack,
    input  logic           i_probe_free,
    output logic [X_W-1:0] o_pos_x,
    output logic [Y_W-1:0] o_pos_y,
    output logic [1:0]     o_dir,
    output logic           o_pend_valid,
    output logic [1:0]     o_pend_dir,
    output logic           o_moving,
    output logic           o_overrun
);
    localparam int unsigned L_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned L_TO_W  = $clog2(PROBE_TO + 1);
    localparam logic [1:0]  DIR_UP    = 2'b00;
    localparam logic [1:0]  DIR_DOWN  = 2'b01;
    localparam logic [1:0]  DIR_LEFT  = 2'b10;
    localparam logic [1:0]  DIR_RIGHT = 2'b11;
    localparam logic [X_W:0] L_X_STEP = (X_W+1)'(STEP);
    localparam logic [Y_W:0] L_Y_STEP = (Y_W+1)'(STEP);
    localparam logic [X_W:0] L_X_MAX  = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] L_Y_MAX  = (Y_W+1)'(Y_MAX);
`ifdef WRAP_TUNNEL_EN
    localparam logic [X_W:0] L_X_SPAN = (X_W+1)'(X_MAX + 1);
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_TURN = 2'd1, S_AHEAD = 2'd2} state_t;

    state_t r_state, w_state_n;
    logic r_pad_d, r_kbd_d, r_tick_pend, r_probe_req, r_pend_valid, r_moving, r_overrun;
    logic [L_CNT_W-1:0] r_tick_cnt;
    logic [L_TO_W-1:0]  r_to_cnt;
    logic [X_W-1:0]     r_probe_x, r_pos_x;
    logic [Y_W-1:0]     r_probe_y, r_pos_y;
    logic [1:0]         r_dir, r_pend_dir;

    logic w_pad_ok, w_kbd_ok, w_req, w_busy, w_entry, w_to, w_done, w_free, w_tick, w_oob;
    logic [1:0] w_pad_dir, w_kbd_dir, w_req_dir, w_tdir;
    logic [X_W:0] w_x_dec, w_x_inc;
    logic [Y_W:0] w_y_dec, w_y_inc;
    logic [X_W-1:0] w_tx;
    logic [Y_W-1:0] w_ty;

    logic w_tick_pend_n, w_probe_req_n, w_pend_valid_n, w_moving_n, w_overrun_n;
    logic [L_CNT_W-1:0] w_tick_cnt_n;
    logic [L_TO_W-1:0]  w_to_cnt_n;
    logic [X_W-1:0]     w_probe_x_n, w_pos_x_n;
    logic [Y_W-1:0]     w_probe_y_n, w_pos_y_n;
    logic [1:0]         w_dir_n, w_pend_dir_n;

    // Key code decode; only a 0->1 valid transition counts as a new request
    always_comb begin
        w_pad_ok  = 1'b1;
        w_pad_dir = DIR_UP;
        case (i_pad_code)
            5'h0C:   w_pad_dir = DIR_LEFT;
            5'h0E:   w_pad_dir = DIR_RIGHT;
            5'h09:   w_pad_dir = DIR_DOWN;
            5'h11:   w_pad_dir = DIR_UP;
            default: w_pad_ok  = 1'b0;
        endcase
        w_kbd_ok  = 1'b1;
        w_kbd_dir = DIR_UP;
        case (i_kbd_code)
            8'h6B:   w_kbd_dir = DIR_LEFT;
            8'h74:   w_kbd_dir = DIR_RIGHT;
            8'h75:   w_kbd_dir = DIR_UP;
            8'h72:   w_kbd_dir = DIR_DOWN;
            default: w_kbd_ok  = 1'b0;
        endcase
    end

    wire w_pad_req = i_pad_valid & ~r_pad_d & w_pad_ok;
    wire w_kbd_req = i_kbd_valid & ~r_kbd_d & w_kbd_ok;
    assign w_req     = w_pad_req | w_kbd_req;
    assign w_req_dir = w_kbd_req ? w_kbd_dir : w_pad_dir;

    // Candidate cell, computed one bit wider so under/overflow is visible
    assign w_tdir  = (r_state == S_TURN) ? r_pend_dir : r_dir;
    assign w_x_dec = {1'b0, r_pos_x} - L_X_STEP;
    assign w_x_inc = {1'b0, r_pos_x} + L_X_STEP;
    assign w_y_dec = {1'b0, r_pos_y} - L_Y_STEP;
    assign w_y_inc = {1'b0, r_pos_y} + L_Y_STEP;

    always_comb begin
        w_tx  = r_pos_x;
        w_ty  = r_pos_y;
        w_oob = 1'b0;
        case (w_tdir)
            DIR_UP: begin
                w_ty  = w_y_dec[Y_W-1:0];
                w_oob = w_y_dec[Y_W];
            end
            DIR_DOWN: begin
                w_ty  = w_y_inc[Y_W-1:0];
                w_oob = (w_y_inc > L_Y_MAX);
            end
            DIR_LEFT: begin
`ifdef WRAP_TUNNEL_EN
                w_tx = w_x_dec[X_W] ? X_W'(w_x_dec + L_X_SPAN) : w_x_dec[X_W-1:0];
`else
                w_tx  = w_x_dec[X_W-1:0];
                w_oob = w_x_dec[X_W];
`endif
            end
            default: begin
`ifdef WRAP_TUNNEL_EN
                w_tx = (w_x_inc > L_X_MAX) ? X_W'(w_x_inc - L_X_SPAN) : w_x_inc[X_W-1:0];
`else
                w_tx  = w_x_inc[X_W-1:0];
                w_oob = (w_x_inc > L_X_MAX);
`endif
            end
        endcase
    end

    // The first busy cycle (req still low) is the probe-launch / bounds-check cycle
    assign w_busy  = (r_state != S_IDLE);
    assign w_entry = w_busy & ~r_probe_req;
    assign w_to    = r_probe_req & (r_to_cnt == L_TO_W'(PROBE_TO - 1));
    assign w_done  = w_busy & (w_entry ? w_oob : (i_probe_ack | w_to));
    assign w_free  = r_probe_req & i_probe_ack & i_probe_free;
    assign w_tick  = (r_tick_cnt == L_CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (r_tick_pend) w_state_n = r_pend_valid ? S_TURN : S_AHEAD;
            S_TURN:  if (w_done) w_state_n = S_AHEAD;
            S_AHEAD: if (w_done) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_comb begin
        w_tick_cnt_n   = w_tick ? '0 : r_tick_cnt + L_CNT_W'(1);
        w_tick_pend_n  = r_tick_pend;
        w_overrun_n    = r_overrun;
        w_probe_req_n  = r_probe_req;
        w_probe_x_n    = r_probe_x;
        w_probe_y_n    = r_probe_y;
        w_to_cnt_n     = r_to_cnt;
        w_pos_x_n      = r_pos_x;
        w_pos_y_n      = r_pos_y;
        w_dir_n        = r_dir;
        w_pend_valid_n = r_pend_valid;
        w_pend_dir_n   = r_pend_dir;
        w_moving_n     = r_moving;

        if (r_state == S_IDLE && r_tick_pend) w_tick_pend_n = 1'b0;
        if (w_tick) begin
            if (r_tick_pend) w_overrun_n   = 1'b1;
            else             w_tick_pend_n = 1'b1;
        end

        if (w_entry && !w_oob) begin
            w_probe_req_n = 1'b1;
            w_probe_x_n   = w_tx;
            w_probe_y_n   = w_ty;
            w_to_cnt_n    = '0;
        end else if (r_probe_req) begin
            if (w_done) w_probe_req_n = 1'b0;
            else        w_to_cnt_n    = r_to_cnt + L_TO_W'(1);
        end

        if (w_done && r_state == S_TURN && w_free) begin
            w_dir_n        = r_pend_dir;
            w_pend_valid_n = 1'b0;
        end
        if (w_done && r_state == S_AHEAD) begin
            w_moving_n = w_free;
            if (w_free) begin
                w_pos_x_n = r_probe_x;
                w_pos_y_n = r_probe_y;
            end
        end

        // While a probe sequence runs, requests are only buffered
        if (w_req) begin
            w_pend_dir_n   = w_req_dir;
            w_pend_valid_n = 1'b1;
            if (!w_busy) begin
                if (w_req_dir == r_dir) begin
                    w_pend_valid_n = 1'b0;
                end else if (w_req_dir == (r_dir ^ 2'b01)) begin
                    w_dir_n        = w_req_dir;
                    w_pend_valid_n = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pad_d      <= 1'b0;
            r_kbd_d      <= 1'b0;
            r_tick_cnt   <= '0;
            r_tick_pend  <= 1'b0;
            r_overrun    <= 1'b0;
            r_probe_req  <= 1'b0;
            r_probe_x    <= '0;
            r_probe_y    <= '0;
            r_to_cnt     <= '0;
            r_pos_x      <= X_W'(X_INIT);
            r_pos_y      <= Y_W'(Y_INIT);
            r_dir        <= DIR_UP;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= DIR_UP;
            r_moving     <= 1'b0;
        end else begin
            r_pad_d      <= i_pad_valid;
            r_kbd_d      <= i_kbd_valid;
            r_tick_cnt   <= w_tick_cnt_n;
            r_tick_pend  <= w_tick_pend_n;
            r_overrun    <= w_overrun_n;
            r_probe_req  <= w_probe_req_n;
            r_probe_x    <= w_probe_x_n;
            r_probe_y    <= w_probe_y_n;
            r_to_cnt     <= w_to_cnt_n;
            r_pos_x      <= w_pos_x_n;
            r_pos_y      <= w_pos_y_n;
            r_dir        <= w_dir_n;
            r_pend_valid <= w_pend_valid_n;
            r_pend_dir   <= w_pend_dir_n;
            r_moving     <= w_moving_n;
        end
    end

    assign o_probe_req  = r_probe_req;
    assign o_probe_x    = r_probe_x;
    assign o_probe_y    = r_probe_y;
    assign o_pos_x      = r_pos_x;
    assign o_pos_y      = r_pos_y;
    assign o_dir        = r_dir;
    assign o_pend_valid = r_pend_valid;
    assign o_pend_dir   = r_pend_dir;
    assign o_moving     = r_moving;
    assign o_overrun    = r_overrun;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: a fast-tick instance served by the bench acting as collision
// checker, plus a TICK_DIV=8 instance with a dead checker for the overrun flag.
module tb_sprite_motion_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pad_valid = 1'b0;
    logic [4:0] pad_code = '0;
    logic       kbd_valid = 1'b0;
    logic [7:0] kbd_code = '0;
    logic       ack = 1'b0;
    logic       free = 1'b0;

    logic       probe_req, pend_valid, moving, overrun;
    logic [9:0] probe_x, pos_x;
    logic [8:0] probe_y, pos_y;
    logic [1:0] dir, pend_dir;

    logic       ov_probe_req, ov_pend_valid, ov_moving, ov_overrun;
    logic [9:0] ov_probe_x, ov_pos_x;
    logic [8:0] ov_probe_y, ov_pos_y;
    logic [1:0] ov_dir, ov_pend_dir;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.TICK_DIV(32)) dut (
        .clk(clk), .rst(rst),
        .i_pad_valid(pad_valid), .i_pad_code(pad_code),
        .i_kbd_valid(kbd_valid), .i_kbd_code(kbd_code),
        .o_probe_req(probe_req), .o_probe_x(probe_x), .o_probe_y(probe_y),
        .i_probe_ack(ack), .i_probe_free(free),
        .o_pos_x(pos_x), .o_pos_y(pos_y), .o_dir(dir),
        .o_pend_valid(pend_valid), .o_pend_dir(pend_dir),
        .o_moving(moving), .o_overrun(overrun)
    );

    sprite_motion_ctrl #(.TICK_DIV(8)) dut_ovr (
        .clk(clk), .rst(rst),
        .i_pad_valid(1'b0), .i_pad_code(5'd0),
        .i_kbd_valid(1'b0), .i_kbd_code(8'd0),
        .o_probe_req(ov_probe_req), .o_probe_x(ov_probe_x), .o_probe_y(ov_probe_y),
        .i_probe_ack(1'b0), .i_probe_free(1'b0),
        .o_pos_x(ov_pos_x), .o_pos_y(ov_pos_y), .o_dir(ov_dir),
        .o_pend_valid(ov_pend_valid), .o_pend_dir(ov_pend_dir),
        .o_moving(ov_moving), .o_overrun(ov_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!probe_req && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("probe_req_seen", 32'(probe_req), 32'd1);
    endtask

    // Act as the collision checker: answer after dly cycles with the given free flag
    task automatic serve(input logic fr, input int dly, output logic [9:0] px, output logic [8:0] py);
        wait_req();
        px = probe_x;
        py = probe_y;
        repeat (dly) @(negedge clk);
        ack  = 1'b1;
        free = fr;
        @(negedge clk);
        ack  = 1'b0;
        free = 1'b0;
    endtask

    task automatic count_req(input logic [9:0] ex, input logic [8:0] ey, output int cnt, output int bad);
        cnt = 0;
        bad = 0;
        while (probe_req && cnt < 40) begin
            if (probe_x != ex || probe_y != ey) bad++;
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [9:0] px;
        logic [8:0] py;
        int cnt, bad, ex;

        repeat (3) @(negedge clk);
        chk("rst_pos_x", 32'(pos_x), 32'd320);
        chk("rst_pos_y", 32'(pos_y), 32'd146);
        chk("rst_dir", 32'(dir), 32'd0);
        chk("rst_pend_valid", 32'(pend_valid), 32'd0);
        chk("rst_probe_req", 32'(probe_req), 32'd0);
        chk("rst_moving", 32'(moving), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_ovr_overrun", 32'(ov_overrun), 32'd0);
        rst = 1'b0;

        // Two plain ticks heading up, checker frees every cell
        serve(1'b1, 1, px, py);
        chk("t1_probe1_x", 32'(px), 32'd320);
        chk("t1_probe1_y", 32'(py), 32'd145);
        chk("t1_pos_y1", 32'(pos_y), 32'd145);
        chk("t1_moving", 32'(moving), 32'd1);
        serve(1'b1, 1, px, py);
        chk("t1_probe2_y", 32'(py), 32'd144);
        chk("t1_pos_y2", 32'(pos_y), 32'd144);
        chk("t1_pos_x", 32'(pos_x), 32'd320);
        chk("t1_dir", 32'(dir), 32'd0);

        // PS/2 left: buffered, committed by TURN, then moved by AHEAD
        kbd_code  = 8'h6B;
        kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
        chk("t2_pend_valid", 32'(pend_valid), 32'd1);
        chk("t2_pend_dir", 32'(pend_dir), 32'd2);
        serve(1'b1, 1, px, py);
        chk("t2_turn_x", 32'(px), 32'd319);
        chk("t2_turn_y", 32'(py), 32'd144);
        chk("t2_dir", 32'(dir), 32'd2);
        chk("t2_pend_cleared", 32'(pend_valid), 32'd0);
        serve(1'b1, 1, px, py);
        chk("t2_ahead_x", 32'(px), 32'd319);
        chk("t2_pos_x", 32'(pos_x), 32'd319);
        chk("t2_moving", 32'(moving), 32'd1);

        // Keypad right while heading left: immediate reversal, no probe
        pad_code  = 5'h0E;
        pad_valid = 1'b1;
        @(negedge clk);
        chk("t3_dir", 32'(dir), 32'd3);
        chk("t3_pend_valid", 32'(pend_valid), 32'd0);
        chk("t3_no_probe", 32'(probe_req), 32'd0);
        pad_code = 5'h0C;
        @(negedge clk);
        chk("t3_held_no_edge", 32'(dir), 32'd3);
        pad_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_still_no_probe", 32'(probe_req), 32'd0);
        serve(1'b1, 1, px, py);
        chk("t3_ahead_x", 32'(px), 32'd320);
        chk("t3_pos_x", 32'(pos_x), 32'd320);

        // Simultaneous pad down / kbd up: kbd wins; checker blocks everything
        pad_code  = 5'h09;
        kbd_code  = 8'h75;
        pad_valid = 1'b1;
        kbd_valid = 1'b1;
        @(negedge clk);
        pad_valid = 1'b0;
        kbd_valid = 1'b0;
        chk("t4_pend_valid", 32'(pend_valid), 32'd1);
        chk("t4_pend_dir", 32'(pend_dir), 32'd0);
        chk("t4_dir", 32'(dir), 32'd3);
        serve(1'b0, 1, px, py);
        chk("t4_turn_x", 32'(px), 32'd320);
        chk("t4_turn_y", 32'(py), 32'd143);
        chk("t4_pend_kept", 32'(pend_valid), 32'd1);
        chk("t4_dir_kept", 32'(dir), 32'd3);
        serve(1'b0, 1, px, py);
        chk("t4_ahead_x", 32'(px), 32'd321);
        chk("t4_moving", 32'(moving), 32'd0);
        chk("t4_pos_x", 32'(pos_x), 32'd320);
        chk("t4_pos_y", 32'(pos_y), 32'd144);

        // Dead checker: each probe times out after 15 cycles with a stable address
        wait_req();
        count_req(10'd320, 9'd143, cnt, bad);
        chk("t5_turn_req_cycles", 32'(cnt), 32'd15);
        chk("t5_turn_addr_stable", 32'(bad), 32'd0);
        wait_req();
        count_req(10'd321, 9'd144, cnt, bad);
        chk("t5_ahead_req_cycles", 32'(cnt), 32'd15);
        chk("t5_ahead_addr_stable", 32'(bad), 32'd0);
        ack  = 1'b1;
        free = 1'b1;
        @(negedge clk);
        ack  = 1'b0;
        free = 1'b0;
        chk("t5_pos_x", 32'(pos_x), 32'd320);
        chk("t5_pos_y", 32'(pos_y), 32'd144);
        chk("t5_moving", 32'(moving), 32'd0);
        chk("t5_pend_valid", 32'(pend_valid), 32'd1);
        chk("t5_dir", 32'(dir), 32'd3);
        chk("t5_ovr_overrun", 32'(ov_overrun), 32'd1);

        // Let the tick phase settle with quick blocked rounds, then reverse to left
        repeat (2) begin
            serve(1'b0, 1, px, py);
            serve(1'b0, 1, px, py);
        end
        pad_code  = 5'h0C;
        pad_valid = 1'b1;
        @(negedge clk);
        pad_valid = 1'b0;
        chk("t6_dir_left", 32'(dir), 32'd2);
        chk("t6_pend_cleared", 32'(pend_valid), 32'd0);

        ex  = 320;
        bad = 0;
        for (int i = 0; i < 320; i++) begin
            serve(1'b1, 1, px, py);
            if (px != 10'(ex - 1) || py != 9'd144) bad++;
            ex--;
        end
        chk("t6_walk_probes", 32'(bad), 32'd0);
        chk("t6_at_left_edge", 32'(pos_x), 32'd0);
`ifdef WRAP_TUNNEL_EN
        serve(1'b1, 1, px, py);
        chk("t6_wrap_probe_x", 32'(px), 32'd639);
        chk("t6_wrap_probe_y", 32'(py), 32'd144);
        chk("t6_wrap_pos_x", 32'(pos_x), 32'd639);
        chk("t6_wrap_moving", 32'(moving), 32'd1);
`else
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (probe_req) cnt++;
        end
        chk("t6_edge_no_probe", 32'(cnt), 32'd0);
        chk("t6_edge_pos_x", 32'(pos_x), 32'd0);
        chk("t6_edge_moving", 32'(moving), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
